// File: rtl/pocket_pad_conditioner.sv
// Per-pad input conditioner: debounce, press/release pulses, connection tracking and
// optional D-pad auto-repeat (built only when POCKET_PAD_REPEAT_EN is defined).
module pocket_pad_conditioner #(
  parameter int NUM_PADS         = 4,
  parameter int DEBOUNCE_SAMPLES = 2,
  parameter int REPEAT_DELAY     = 24,
  parameter int REPEAT_RATE      = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_i,
  input  logic [NUM_PADS*32-1:0] key_i,
  output logic [NUM_PADS*16-1:0] held_o,
  output logic [NUM_PADS*16-1:0] press_o,
  output logic [NUM_PADS*16-1:0] release_o,
  output logic [NUM_PADS*4-1:0]  repeat_o,
  output logic [NUM_PADS*4-1:0]  type_o,
  output logic [NUM_PADS-1:0]    connected_o,
  output logic [NUM_PADS-1:0]    type_change_o
);

  localparam logic [3:0] CTRL_NONE = 4'd0;
  localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_SAMPLES - 1);

`ifndef POCKET_PAD_REPEAT_EN
  localparam int rpt_params_unused = REPEAT_DELAY + REPEAT_RATE;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [15:0]      w_raw;
      logic [3:0]       w_type_new;
      logic             w_key_unused;
      logic [15:0]      w_held_next;
      logic [15:0][3:0] w_cnt_next;
      logic [15:0]      r_held;
      logic [15:0]      r_press;
      logic [15:0]      r_release;
      logic [15:0][3:0] r_cnt;
      logic [3:0]       r_type;
      logic             r_type_change;

      assign w_raw        = key_i[32*gi +: 16];
      assign w_type_new   = key_i[32*gi+28 +: 4];
      assign w_key_unused = ^key_i[32*gi+16 +: 12];

      // A none-type sample wipes the pad; otherwise each bit runs its own debounce counter.
      always_comb begin
        w_held_next = r_held;
        w_cnt_next  = r_cnt;
        if (w_type_new == CTRL_NONE) begin
          w_held_next = '0;
          w_cnt_next  = '0;
        end else begin
          for (int b = 0; b < 16; b++) begin
            if (w_raw[b] == r_held[b]) begin
              w_cnt_next[b] = 4'd0;
            end else if (r_cnt[b] == DEB_LAST) begin
              w_held_next[b] = ~r_held[b];
              w_cnt_next[b]  = 4'd0;
            end else begin
              w_cnt_next[b] = r_cnt[b] + 4'd1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_held        <= '0;
          r_press       <= '0;
          r_release     <= '0;
          r_cnt         <= '0;
          r_type        <= CTRL_NONE;
          r_type_change <= 1'b0;
        end else begin
          r_press       <= '0;
          r_release     <= '0;
          r_type_change <= 1'b0;
          if (sample_i) begin
            r_held        <= w_held_next;
            r_cnt         <= w_cnt_next;
            r_press       <= w_held_next & ~r_held;
            r_release     <= r_held & ~w_held_next;
            r_type        <= w_type_new;
            r_type_change <= (w_type_new != r_type);
          end
        end
      end

      assign held_o[16*gi +: 16]    = r_held;
      assign press_o[16*gi +: 16]   = r_press;
      assign release_o[16*gi +: 16] = r_release;
      assign type_o[4*gi +: 4]      = r_type;
      assign connected_o[gi]        = (r_type != CTRL_NONE);
      assign type_change_o[gi]      = r_type_change;

`ifdef POCKET_PAD_REPEAT_EN
      logic [3:0][7:0] r_rpt_cnt;
      logic [3:0]      r_repeat;

      // Counter at 0 means idle; a press loads the initial delay, hitting 1 fires and reloads.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rpt_cnt <= '0;
          r_repeat  <= '0;
        end else begin
          r_repeat <= '0;
          if (sample_i) begin
            for (int b = 0; b < 4; b++) begin
              if (w_held_next[b] && !r_held[b]) begin
                r_repeat[b]  <= 1'b1;
                r_rpt_cnt[b] <= 8'(REPEAT_DELAY);
              end else if (w_held_next[b]) begin
                if (r_rpt_cnt[b] == 8'd1) begin
                  r_repeat[b]  <= 1'b1;
                  r_rpt_cnt[b] <= 8'(REPEAT_RATE);
                end else if (r_rpt_cnt[b] != 8'd0) begin
                  r_rpt_cnt[b] <= r_rpt_cnt[b] - 8'd1;
                end
              end else begin
                r_rpt_cnt[b] <= 8'd0;
              end
            end
          end
        end
      end

      assign repeat_o[4*gi +: 4] = r_repeat;
`else
      assign repeat_o[4*gi +: 4] = 4'b0000;
`endif
    end
  endgenerate

endmodule

// File: doc/pocket_pad_conditioner.md
# pocket_pad_conditioner

Multi-pad controller input conditioner between the APF controller registers and core logic. Takes raw 32-bit key words for up to NUM_PADS controllers in the `pocket::key_t` layout and produces, per pad:
- debounced held state;
- one-cycle press and release pulses;
- D-pad auto-repeat pulses for menu navigation;
- connection tracking derived from the controller-type field.

All updates advance only on a sample strobe, normally the frame tick.

## Interface
- NUM_PADS, 4: number of controller channels, 1..4.
- DEBOUNCE_SAMPLES, 2: consecutive disagreeing samples required to flip a held bit, 1..15.
- REPEAT_DELAY, 24: samples from press to first auto-repeat, 1..255.
- REPEAT_RATE, 6: samples between subsequent auto-repeats, 1..255.
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_i  in  1  sample strobe; one sample per high cycle.
- key_i  in  NUM_PADS*32  raw key words, pad p at bits [32p+31:32p], `key_t` layout.
- held_o  out  NUM_PADS*16  debounced button state, pad p at [16p+15:16p], bit order = `key_t` bits 15:0.
- press_o  out  NUM_PADS*16  one-cycle pulse on each held 0->1.
- release_o  out  NUM_PADS*16  one-cycle pulse on each held 1->0.
- repeat_o  out  NUM_PADS*4  D-pad repeat pulses, pad p at [4p+3:4p]: up, down, left, right.
- type_o  out  NUM_PADS*4  registered `controller_type_t` per pad.
- connected_o  out  NUM_PADS  1 when type_o != `controller_none`.
- type_change_o  out  NUM_PADS  one-cycle pulse when a sampled type differs from type_o.

## Operation
- Reset: every output 0, every debounce and repeat counter 0; type_o = 0 (`controller_none`).
- Inputs are consumed only in cycles with sample_i = 1. Bits 27:16 of each key word are ignored.
- **Type tracking:** on each sample, type_o <= key[31:28]. type_change_o pulses if the new value differs from the old type_o.
- **Debounce, per button:**
  - 4-bit counter, compared against raw bit b and held bit h.
  - raw == h: counter cleared.
  - raw != h and counter == DEBOUNCE_SAMPLES-1: h toggles, counter cleared.
  - Otherwise the counter increments.
  - DEBOUNCE_SAMPLES = 1 means h follows raw on every sample.
- **Disconnect:** a sample whose type is `controller_none` forces all 16 held bits of that pad to 0, bypassing debounce. It also clears that pad's counters and pulses release_o for each bit that was 1. While the type stays none, raw bits are ignored.
- **Connect:** on the first sample with a non-none type, debounce starts from held = 0 with counters at 0.
- **Pulses:** press_o / release_o bits assert for exactly one cycle, in the cycle held_o changes. A bit never pulses in consecutive cycles unless held_o changes in consecutive samples.
- **Auto-repeat, per D-pad bit (8-bit counter):**
  - Press edge: repeat_o pulses and the counter loads REPEAT_DELAY.
  - While held, each sample decrements the counter.
  - A sample that finds the counter at 1 pulses repeat_o and reloads REPEAT_RATE.
  - Release or disconnect clears the counter; no pulse.

## Timing
- Latency: sample in cycle t; held_o, type_o, connected_o and all pulses update at the clk edge ending cycle t and are visible in cycle t+1.
- Pulse outputs are 0 in every cycle not directly following a sample.
- sample_i held high: every cycle is a sample, and pulses may assert in back-to-back cycles.
- Reset asserted mid-operation: outputs clear asynchronously, and no pulses are emitted on deassertion. The first sample after reset compares against held = 0, type = none.
- Sample with a type change between two non-none values: type_change_o pulses, and held state and counters are preserved.
- Fully synchronous datapath; no combinational path from inputs to outputs.

## Configuration
- POCKET_PAD_REPEAT_EN defined: auto-repeat counters and logic are built, behaving as described above.
- Undefined: repeat_o is constant 0, no repeat counters are instantiated, and REPEAT_DELAY / REPEAT_RATE are ignored. All other behaviour is identical.

## Test plan
- Debounce: DEBOUNCE_SAMPLES=2, pad0 type=1, face_a raw 1 for one sample then 0 -> held_o[4] stays 0 and no press. Raw 1 for two samples -> held_o[4]=1 in the cycle after the 2nd sample, with a single press_o[4] pulse.
- Release: held face_b, raw 0 for 2 samples -> release_o[5] pulses once and held_o[5]=0.
- Disconnect: pad1 holding dpad_up and trig_l1, type goes 1->0 -> held_o[31:16]=0 on the next cycle, release_o pulses bits 16 and 24, type_change_o[1]=1, connected_o[1]=0.
- Auto-repeat (macro defined): DELAY=3, RATE=2, DEBOUNCE=1, dpad_right held 10 samples -> repeat_o[3] pulses after samples 1, 4, 6, 8, 10. Release -> no further pulses.
- Repeat compiled out: same stimulus -> repeat_o stays 0, and press_o behaves identically.
- Async reset mid-hold: reset_n low during a held button -> all outputs 0 immediately. After release of reset, the next sample with raw 1 takes DEBOUNCE_SAMPLES samples to set held again.
